// File: rtl/nanov_alu_pkg.sv
// Shared definitions for the nanov multi-cycle ALU: funct3 encodings, FSM states, default sizes.
// The optional serial shifter is built only when NANOV_ALU_SHIFT_EN is defined.
package nanov_alu_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_SLICE = 8;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam int OP_ALT_BIT = 3;

`ifdef NANOV_ALU_SHIFT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARITH = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARITH = 2'd1
    } state_t;
`endif

    function automatic logic is_shift(input logic [2:0] f3);
        logic r;
        case (f3)
            F3_SLL:  r = 1'b1;
            F3_SR:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // SUB, SLT and SLTU all run through the adder as a + ~b + 1
    function automatic logic uses_sub(input logic [3:0] op);
        logic r;
        case (op[2:0])
            F3_ADD:  r = op[OP_ALT_BIT];
            F3_SLT:  r = 1'b1;
            F3_SLTU: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/nanov_alu_mc_if.sv
// Request/result bundle of the nanov multi-cycle ALU.
// master drives the request, slave (the ALU) returns status and result.
interface nanov_alu_mc_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] d;

    modport master (
        output start, op, a, b,
        input  ready, busy, done, d
    );

    modport slave (
        input  start, op, a, b,
        output ready, busy, done, d
    );
endinterface

// File: rtl/nanov_alu_slice.sv
// One SLICE-wide step of the ALU: add with carry plus the bitwise results.
// Purely combinational; the top reuses a single instance for every slice.
module nanov_alu_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic [SLICE-1:0] x_xor,
    output logic [SLICE-1:0] x_or,
    output logic [SLICE-1:0] x_and
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
    assign x_xor       = x ^ y;
    assign x_or        = x | y;
    assign x_and       = x & y;
endmodule

// File: rtl/nanov_alu_mc.sv
// Multi-cycle RV32-style integer ALU: slice-serial add/compare/logic, bit-serial shifts.
// Define NANOV_ALU_SHIFT_EN to build the shifter; otherwise shift ops return 0 after one cycle.
module nanov_alu_mc
    import nanov_alu_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int SLICE = DEF_SLICE
) (
    input  logic           clk,
    input  logic           rst,
    nanov_alu_mc_if.slave  bus
);

    localparam int N     = XLEN / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    if ((XLEN % SLICE) != 0) begin : g_slice_check
        $error("nanov_alu_mc: XLEN must be a multiple of SLICE");
    end

    state_t                     state_r, state_nxt_s;
    logic [XLEN-1:0]            a_r, a_nxt_s;
    logic [XLEN-1:0]            b_r, b_nxt_s;
    logic [3:0]                 op_r, op_nxt_s;
    logic [N-1:0][SLICE-1:0]    res_r, res_nxt_s;
    logic                       carry_r, carry_nxt_s;
    logic [IDX_W-1:0]           idx_r, idx_nxt_s;
    logic [XLEN-1:0]            d_r, d_nxt_s;
    logic                       done_r, done_nxt_s;
    logic                       ready_r, busy_r;

    logic                       idle_s;
    logic [XLEN-1:0]            cur_a_s, cur_b_s;
    logic [3:0]                 cur_op_s;
    logic                       cin_s, sub_s, last_s;
    logic [N-1:0][SLICE-1:0]    a_sl_s, b_sl_s, res_fin_s;
    logic [SLICE-1:0]           x_s, y_s, sl_sum_s, sl_xor_s, sl_or_s, sl_and_s, sl_res_s;
    logic                       sl_cout_s, lt_s, ltu_s;
    logic [XLEN-1:0]            arith_d_s;

`ifdef NANOV_ALU_SHIFT_EN
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] SH_ONE  = SHW'(1);
    localparam logic [SHW-1:0] SH_ZERO = {SHW{1'b0}};

    logic [XLEN-1:0] sh_r, sh_nxt_s;
    logic [SHW-1:0]  cnt_r, cnt_nxt_s;
    logic [SHW-1:0]  shamt_s;

    assign shamt_s = bus.b[SHW-1:0];

    function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input logic [3:0] o);
        logic [XLEN-1:0] r;
        case (o[2:0])
            F3_SLL:  r = {v[XLEN-2:0], 1'b0};
            F3_SR:   r = {(o[OP_ALT_BIT] ? v[XLEN-1] : 1'b0), v[XLEN-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction
`endif

    assign idle_s = (state_r == ST_IDLE);

    // Operand source: live bus in the accepting cycle, captured copy afterwards
    always_comb begin
        if (idle_s) begin
            cur_a_s  = bus.a;
            cur_b_s  = bus.b;
            cur_op_s = bus.op;
            cin_s    = uses_sub(bus.op);
        end else begin
            cur_a_s  = a_r;
            cur_b_s  = b_r;
            cur_op_s = op_r;
            cin_s    = carry_r;
        end
    end

    assign a_sl_s = cur_a_s;
    assign b_sl_s = cur_b_s;
    assign sub_s  = uses_sub(cur_op_s);
    assign x_s    = a_sl_s[idx_r];
    assign y_s    = sub_s ? ~b_sl_s[idx_r] : b_sl_s[idx_r];
    assign last_s = (idx_r == LAST_IDX);

    nanov_alu_slice #(.SLICE(SLICE)) u_slice (
        .x     (x_s),
        .y     (y_s),
        .cin   (cin_s),
        .sum   (sl_sum_s),
        .cout  (sl_cout_s),
        .x_xor (sl_xor_s),
        .x_or  (sl_or_s),
        .x_and (sl_and_s)
    );

    // Slice result select and the full-width result produced on the last slice
    always_comb begin
        case (cur_op_s[2:0])
            F3_XOR:  sl_res_s = sl_xor_s;
            F3_OR:   sl_res_s = sl_or_s;
            F3_AND:  sl_res_s = sl_and_s;
            default: sl_res_s = sl_sum_s;
        endcase
        res_fin_s        = res_r;
        res_fin_s[idx_r] = sl_res_s;
        // Signed compare: differing signs decide directly, otherwise the difference sign does
        lt_s  = (cur_a_s[XLEN-1] != cur_b_s[XLEN-1]) ? cur_a_s[XLEN-1] : sl_sum_s[SLICE-1];
        ltu_s = ~sl_cout_s;
        case (cur_op_s[2:0])
            F3_SLT:  arith_d_s = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: arith_d_s = {{(XLEN-1){1'b0}}, ltu_s};
            default: arith_d_s = res_fin_s;
        endcase
    end

    // FSM next state and datapath next values
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        op_nxt_s    = op_r;
        res_nxt_s   = res_r;
        carry_nxt_s = carry_r;
        idx_nxt_s   = idx_r;
        d_nxt_s     = d_r;
        done_nxt_s  = 1'b0;
`ifdef NANOV_ALU_SHIFT_EN
        sh_nxt_s    = sh_r;
        cnt_nxt_s   = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    a_nxt_s  = bus.a;
                    b_nxt_s  = bus.b;
                    op_nxt_s = bus.op;
                    if (is_shift(bus.op[2:0])) begin
`ifdef NANOV_ALU_SHIFT_EN
                        // The accepting edge already performs the first one-bit step
                        if (shamt_s <= SH_ONE) begin
                            d_nxt_s    = (shamt_s == SH_ZERO) ? bus.a : shift1(bus.a, bus.op);
                            done_nxt_s = 1'b1;
                        end else begin
                            sh_nxt_s    = shift1(bus.a, bus.op);
                            cnt_nxt_s   = shamt_s - SH_ONE;
                            state_nxt_s = ST_SHIFT;
                        end
`else
                        d_nxt_s    = {XLEN{1'b0}};
                        done_nxt_s = 1'b1;
`endif
                    end else if (last_s) begin
                        d_nxt_s    = arith_d_s;
                        done_nxt_s = 1'b1;
                    end else begin
                        res_nxt_s   = res_fin_s;
                        carry_nxt_s = sl_cout_s;
                        idx_nxt_s   = idx_r + IDX_ONE;
                        state_nxt_s = ST_ARITH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARITH: begin
                if (last_s) begin
                    d_nxt_s     = arith_d_s;
                    done_nxt_s  = 1'b1;
                    carry_nxt_s = 1'b0;
                    idx_nxt_s   = IDX_ZERO;
                    state_nxt_s = ST_IDLE;
                end else begin
                    res_nxt_s   = res_fin_s;
                    carry_nxt_s = sl_cout_s;
                    idx_nxt_s   = idx_r + IDX_ONE;
                end
            end
`ifdef NANOV_ALU_SHIFT_EN
            ST_SHIFT: begin
                if (cnt_r == SH_ONE) begin
                    d_nxt_s     = shift1(sh_r, op_r);
                    done_nxt_s  = 1'b1;
                    cnt_nxt_s   = SH_ZERO;
                    state_nxt_s = ST_IDLE;
                end else begin
                    sh_nxt_s  = shift1(sh_r, op_r);
                    cnt_nxt_s = cnt_r - SH_ONE;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; reset aborts any running operation
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {XLEN{1'b0}};
            b_r     <= {XLEN{1'b0}};
            op_r    <= 4'b0000;
            res_r   <= {(N*SLICE){1'b0}};
            carry_r <= 1'b0;
            idx_r   <= IDX_ZERO;
            d_r     <= {XLEN{1'b0}};
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            op_r    <= op_nxt_s;
            res_r   <= res_nxt_s;
            carry_r <= carry_nxt_s;
            idx_r   <= idx_nxt_s;
            d_r     <= d_nxt_s;
            done_r  <= done_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

`ifdef NANOV_ALU_SHIFT_EN
    // Shifter working register and remaining-step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_r  <= {XLEN{1'b0}};
            cnt_r <= SH_ZERO;
        end else begin
            sh_r  <= sh_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.d     = d_r;

endmodule

// File: doc/nanov_alu_mc.md
NANOV_ALU_MC -- requirements
Module: nanov_alu_mc

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits.
REQ-002 Parameter SLICE, default 8: bits processed per cycle by add, compare and logic ops; XLEN SHALL be a multiple of SLICE (elaboration error otherwise).
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request; accepted only when ready=1.
REQ-006 op  in  4  op[2:0]=funct3, op[3]=alt (SUB/SRA select).
REQ-007 a, b  in  XLEN  operands; sampled on the accepting edge only.
REQ-008 ready  out  1  high when idle and able to accept start.
REQ-009 busy  out  1  high while an operation is in progress; equal to ~ready.
REQ-010 done  out  1  one-cycle pulse when d holds a new result.
REQ-011 d  out  XLEN  result; held stable from done until the next done.

Function
REQ-012 Ops: 000 ADD/SUB(alt), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA(alt), 110 OR, 111 AND; alt ignored for all other ops.
REQ-013 FSM states IDLE, ARITH, SHIFT; IDLE->ARITH on accepted non-shift op; IDLE->SHIFT on accepted shift op; ARITH/SHIFT->IDLE on final step.
REQ-014 ARITH processes SLICE bits per cycle LSB first, carry/borrow registered between slices; latency N=XLEN/SLICE.
REQ-015 Latency counted with the accepting cycle as cycle 0: done is high in cycle N, for exactly one cycle.
REQ-016 ADD/SUB results wrap modulo 2^XLEN; SUB computed as a + ~b + 1.
REQ-017 SLTU: d=1 iff the borrow out of a-b is set; SLT: d=1 iff (a[MSB]!=b[MSB]) ? a[MSB] : diff[MSB]; upper XLEN-1 bits zero.
REQ-018 Shift amount = b[clog2(XLEN)-1:0]; upper bits of b ignored.
REQ-019 SHIFT moves one bit per cycle; latency N=max(shamt,1); shamt=0 yields d=a in cycle 1.
REQ-020 SRA fills with a[MSB]; SRL and SLL fill with zero.
REQ-021 ready=1 in the done cycle; a start in that cycle is accepted (back-to-back, no bubble).
REQ-022 start while busy is ignored; operands and op of the running operation are unaffected.
REQ-023 d changes only on the edge that raises done; partial results are never visible on d.

Reset
REQ-024 rst=1: state IDLE, ready=1, busy=0, done=0, d=0, carry and counters cleared.
REQ-025 rst during ARITH or SHIFT aborts the operation with no done pulse; rst has priority over start.

Configuration
REQ-026 Macro NANOV_ALU_SHIFT_EN defined: SLL/SRL/SRA implemented per REQ-019/020.
REQ-027 Macro NANOV_ALU_SHIFT_EN undefined: no SHIFT state or shifter; shift ops complete with latency 1 and d=0.

Structure
REQ-028 Package nanov_alu_pkg: op encodings (funct3 and alt), FSM state encoding, default XLEN and SLICE.
REQ-029 Sub-module nanov_alu_slice: combinational SLICE-wide add/xor/or/and with carry-in and carry-out, instantiated once and reused for every slice.

Verification
REQ-030 Defaults; ADD a=0xFFFFFFFF b=0x00000001 -> d=0x00000000, done in cycle 4 only.
REQ-031 SUB a=5 b=7 -> d=0xFFFFFFFE; SLT a=0xFFFFFFFF b=1 -> d=1; SLTU same operands -> d=0.
REQ-032 SRA a=0x80000000 b=0x24 (shamt 4) -> d=0xF8000000, done in cycle 4; SLL shamt 0 -> d=a, done in cycle 1.
REQ-033 Start during busy with different op/operands -> ignored, first result unchanged; start in the done cycle -> second done exactly N cycles later.
REQ-034 rst asserted in cycle 2 of an ADD -> no done, d=0, ready=1 next cycle.
REQ-035 Build without NANOV_ALU_SHIFT_EN; SRL a=0xF0 b=4 -> d=0, done in cycle 1.
